// File: rtl/word_arbiter_16.sv
// Round-robin arbiter sharing one 32-bit registered result path among 16 requesters.
// Contains the 16:1 word mux used for the data path and the arbiter/output register top.

module mux_16 (
   input  logic [511:0] data,
   input  logic [3:0]   sel,
   output logic [31:0]  y
);

   always_comb begin
      y = data[32*sel +: 32];
   end

endmodule

module word_arbiter_16 #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [15:0]         req,
   input  logic [16*WIDTH-1:0] in_data,
   output logic [15:0]         ack,
   output logic                out_valid,
   output logic [WIDTH-1:0]    out_data,
   output logic [3:0]          out_src,
   input  logic                out_ready
);

   logic [3:0]       ptr_q;
   logic [15:0]      ack_q;
   logic             valid_q;
   logic [WIDTH-1:0] data_q;
   logic [3:0]       src_q;

   logic [15:0]      ereq;
   logic [31:0]      rot_wide;
   logic [15:0]      rot;
   logic [3:0]       offset;
   logic [3:0]       winner;
   logic             can_load;
   logic             capture;
   logic [WIDTH-1:0] mux_word;

   // Masking by the current ack prevents the same word being captured twice.
   assign ereq = req & ~ack_q;

   // Rotate so that index ptr lands at bit 0; the lowest set bit is then the winner offset.
   assign rot_wide = {ereq, ereq} >> ptr_q;
   assign rot      = rot_wide[15:0];

   always_comb begin
      offset = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (rot[i]) begin
            offset = 4'(i);
         end
      end
   end

   assign winner   = ptr_q + offset;
   assign can_load = ~valid_q | out_ready;
   assign capture  = can_load & (|ereq);

   mux_16 u_mux (
      .data (in_data),
      .sel  (winner),
      .y    (mux_word)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q   <= 4'd0;
         ack_q   <= 16'd0;
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= 4'd0;
      end else if (capture) begin
         ptr_q   <= winner + 4'd1;
         ack_q   <= 16'd1 << winner;
         valid_q <= 1'b1;
         data_q  <= mux_word;
         src_q   <= winner;
      end else begin
         ack_q <= 16'd0;
         if (valid_q && out_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign ack       = ack_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_src   = src_q;

endmodule

// File: doc/word_arbiter_16.md
# word_arbiter_16

Round-robin arbiter and output register that shares one 32-bit result path among 16 requesters. Each cycle it picks at most one requesting source fairly. It routes that source's word through an internal `mux_16` instance and captures the word into an output register. It then holds the word under a valid/ready handshake until the downstream consumer accepts it. It sits between the 16 producer ports and the single shared consumer, for example a writeback or bus port, and replaces ad-hoc fixed-priority select logic.

## Interface
- `WIDTH`, 32, data word width; fixed at 32 to match `mux_16`.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`.
- `req`  in  16  request per source; bit i high means `in_data[32*i+31:32*i]` is valid.
- `in_data`  in  512  flattened source words; source i at bits [32*i+31:32*i].
- `ack`  out  16  one-hot, one-cycle pulse; bit i high means source i's word was captured.
- `out_valid`  out  1  `out_data` holds an unaccepted word.
- `out_data`  out  32  captured word.
- `out_src`  out  4  index of the source that produced `out_data`.
- `out_ready`  in  1  consumer accepts `out_data` when high together with `out_valid`.

## Operation
- Internal state:
  - `ptr` (4 bits): highest-priority index.
  - Output register: `out_valid`, `out_data`, `out_src`.
  - `ack` register.
- Effective request: `ereq = req & ~ack`. A source whose ack is currently high is ignored that cycle, which prevents double capture.
- Winner selection:
  - Search `ereq` starting at index `ptr`, then ptr+1, … wrapping 15→0.
  - The first set bit is winner `w`.
  - The winner is computed with 4-bit modulo-16 arithmetic.
- Data path: `w` drives the select of an internal `mux_16`; the mux output is the capture data.
- Capture condition is `can_load = ~out_valid | out_ready`, i.e. the register is empty or being drained this cycle. A capture happens when `can_load` is high and `ereq` is nonzero. On a capture edge:
  - `out_data` ← word w.
  - `out_src` ← w.
  - `out_valid` ← 1.
  - `ack` ← one-hot(w).
  - `ptr` ← w+1 mod 16, so 15 wraps to 0.
- Drain without refill: when `out_valid & out_ready` is high and nothing is captured, set `out_valid` ← 0. `out_data` and `out_src` hold their last values.
- No capture: `ack` ← 0 and `ptr` unchanged.
- Stall: while `out_valid` is high and `out_ready` is low, `out_data`, `out_src`, `out_valid` and `ptr` hold. Requests wait and no ack is issued.
- Effective states:
  - EMPTY (`out_valid`=0): transitions to FULL on capture.
  - FULL (`out_valid`=1):
    - stays FULL on stall;
    - stays FULL on accept with a new capture;
    - goes to EMPTY on accept with no `ereq`.
- `out_ready` while `out_valid`=0 has no effect.
- A source may deassert `req` before being granted. It is simply skipped, and this is not an error.
- Reset:
  - All outputs are 0: `out_valid`=0, `out_data`=0, `out_src`=0, `ack`=0.
  - `ptr`=0.
  - A word pending mid-handshake is discarded, and no ack is issued for requests in the reset cycle.

## Timing
- Latency: `req[i]` high at edge N with the register empty gives `out_valid`=1 and `ack[i]`=1 after edge N. Total latency is one cycle.
- `ack` lasts exactly one cycle. The source must drop `req` or present a new word during the ack cycle. `req` still high after the ack cycle is treated as a new request.
- Throughput: one word per cycle while `out_ready` stays high. A single source with continuous `req` gets every other cycle because of the ack masking.
- The combinational path `req`/`in_data` → `mux_16` → output register is contained within one cycle. No outputs are combinational from inputs.

## Test plan
- **Reset values:** assert `reset` for 2 cycles with `req`=16'hFFFF. Required: `out_valid`=0, `out_data`=0, `out_src`=0, `ack`=0 throughout; first capture after release is source 0.
- **Single request:** `req`=16'h0020, word5=32'hDEADBEEF, `out_ready`=1. Required:
  - next cycle `out_valid`=1, `out_data`=32'hDEADBEEF, `out_src`=5, `ack`=16'h0020;
  - `ptr` becomes 6.
- **Round-robin wrap:** `req`=16'h8001 held, `out_ready`=1, with each source's `req` re-presented after its ack cycle. Required: grants alternate 0, 15, 0, 15, …; after granting 15, `ptr` wraps to 0.
- **Stall:** with `out_valid`=1 and `out_src`=3, hold `out_ready`=0 for 4 cycles while `req`=16'h0010. Required:
  - `out_data` and `out_src` are stable;
  - `ack`=0 during the stall;
  - on the cycle `out_ready`=1, source 4 is captured in the same edge (back-to-back).
- **All requesting:** `req`=16'hFFFF continuously from `ptr`=0, `out_ready`=1. Required: `out_src` sequence is 0, 1, 2, … 15, 0; no source is skipped or repeated.
- **Reset mid-operation:** `out_valid`=1 and `out_ready`=0, then assert `reset`. Required: next cycle `out_valid`=0 and `ack`=0; the pending word is never presented as accepted.
